// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One spare bit so the counter can reach WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_nand.sv
// One-bit full adder built purely from 2-input NAND gates.
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, x1, n4, n5, n6;

  // x1 = a ^ b; n1 and n4 double as the carry terms.
  nand g1 (n1, a, b);
  nand g2 (n2, a, n1);
  nand g3 (n3, b, n1);
  nand g4 (x1, n2, n3);
  nand g5 (n4, x1, cin);
  nand g6 (n5, x1, n4);
  nand g7 (n6, cin, n4);
  nand g8 (sum, n5, n6);
  nand g9 (cout, n4, n1);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one shared full adder, one bit per clock, LSB first.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CntW-1:0] cnt_q;
  logic            carry_q, cout_q, ovf_q, done_q, busy_q;
  logic            fa_sum, fa_cout;

  fa_nand u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert b here, seed carry with 1.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= {fa_sum, result_q[WIDTH-1:1]};
          a_q      <= {1'b0, a_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1, mode select (0 = a+b, 1 = a-b); sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH, first operand; sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, WIDTH, sum or difference.
REQ-011 The block SHALL have port cout, output, 1, final carry (sub mode: 1 = no borrow, i.e. a >= b unsigned).
REQ-012 The block SHALL have port ovf, output, 1, two's-complement overflow.

Function
REQ-013 The block SHALL compute every bit through one shared 1-bit full-adder instance, one bit per clock, LSB first.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a into shift register A, b XOR {WIDTH{sub}} into shift register B, set carry = sub, clear the bit counter and go to RUN.
REQ-016 Each RUN cycle SHALL:
- feed A[0], B[0] and carry to the full adder;
- shift the sum bit into result at the MSB, shifting right;
- shift A and B right;
- register carry-out into carry;
- increment the counter.
REQ-017 After the WIDTH-th RUN cycle (counter = WIDTH-1), the FSM SHALL go to DONE.
REQ-018 The block SHALL register ovf as (carry into MSB) XOR (carry out of MSB) during the last RUN cycle.
REQ-019 In DONE the block SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: done SHALL assert WIDTH+1 cycles after the clock edge that samples start.
REQ-021 result, cout and ovf SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-022 start SHALL be ignored in RUN and DONE, with no queuing and no effect on the operation in progress.
REQ-023 Changes on a, b or sub after start is sampled SHALL NOT affect the operation in progress.
REQ-024 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-025 When rst_n=0 the block SHALL asynchronously force IDLE and clear result, cout, ovf, done, busy, carry, counter, A and B to 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation, with no done pulse.
REQ-027 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package serial_addsub_pkg SHALL hold:
- the state enum typedef (IDLE, RUN, DONE);
- a function returning the counter width for a given WIDTH.
REQ-029 The full adder SHALL be a separate sub-module fa_nand (ports a, b, cin, sum, cout) built only from 2-input NAND primitives.
REQ-030 serial_addsub_ctrl SHALL instantiate fa_nand exactly once; no other arithmetic operators are permitted on the datapath.

Verification (WIDTH=8)
REQ-031 add 8'h0F + 8'h01: done exactly 9 cycles after start, with result=8'h10, cout=0, ovf=0.
REQ-032 add 8'hFF + 8'h01 SHALL give result=8'h00, cout=1, ovf=0; add 8'h7F + 8'h01 SHALL give result=8'h80, cout=0, ovf=1.
REQ-033 sub 8'h05 - 8'h07 SHALL give result=8'hFE, cout=0, ovf=0; sub 8'h80 - 8'h01 SHALL give result=8'h7F, cout=1, ovf=1.
REQ-034 Start pulsed at RUN cycle 3 with different operands SHALL leave the first result unchanged and produce exactly one done.
REQ-035 rst_n low during RUN cycle 4: outputs SHALL read 0 and busy=0 immediately, with no done; a new start after release SHALL complete correctly.
REQ-036 Back-to-back: start in the first IDLE cycle after done SHALL be accepted, giving a second done 9 cycles later.
